// File: rtl/sd_fifo_ctrl.sv
// First-word-fall-through FIFO controller driving one dual-port BRAM:
// port A write-only, port B read-only with a registered output.
module sd_fifo_ctrl #(
  parameter int unsigned DATA = 32,
  parameter int unsigned ADDR = 7
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  // write side (SD data engine)
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [DATA-1:0]   wr_data_i,
  // read side (bus DMA)
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [DATA-1:0]   rd_data_o,
  // occupancy
  output logic [ADDR:0]     level_o,
  input  logic [ADDR:0]     thresh_i,
  output logic              at_thresh_o,
  // BRAM port A (write) and port B (read)
  output logic              mem_wr_o,
  output logic [ADDR-1:0]   mem_waddr_o,
  output logic [DATA-1:0]   mem_wdata_o,
  output logic [ADDR-1:0]   mem_raddr_o,
  input  logic [DATA-1:0]   mem_rdout_i
);

  localparam int unsigned DEPTH = 1 << ADDR;
  localparam int unsigned CW    = ADDR + 1;

  logic [ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wr_lag_q, wr_lag_d;
  logic            at_thresh_q, at_thresh_d;

  logic            full;
  logic            push;
  logic            pop;
  logic [CW-1:0]   avail;

  // Write acceptance depends only on registered occupancy, never on the reader.
  assign full       = (count_q == CW'(DEPTH));
  assign wr_ready_o = rst_n_i & ~flush_i & ~full;
  assign push       = wr_valid_i & wr_ready_o;

  // A word pushed last edge is in the BRAM but not yet on port B's output.
  assign avail      = count_q - CW'(wr_lag_q);
  assign rd_valid_o = (avail != '0);
  assign pop        = rd_valid_o & rd_ready_i & ~flush_i;

  assign mem_wr_o    = push;
  assign mem_waddr_o = wr_ptr_q;
  assign mem_wdata_o = wr_data_i;
  // Pre-advance the read address on pop so the next head lands one cycle later.
  assign mem_raddr_o = pop ? (rd_ptr_q + ADDR'(1)) : rd_ptr_q;
  assign rd_data_o   = mem_rdout_i;

  assign level_o     = count_q;
  assign at_thresh_o = at_thresh_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_lag_d = 1'b0;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + ADDR'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ADDR'(1);
      end
      count_d  = count_q + CW'(push) - CW'(pop);
      wr_lag_d = push;
    end
    at_thresh_d = (count_d >= thresh_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_lag_q    <= 1'b0;
      at_thresh_q <= (thresh_i == '0);
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_lag_q    <= wr_lag_d;
      at_thresh_q <= at_thresh_d;
    end
  end

endmodule

// File: tb/tb_sd_fifo_ctrl.sv
// Bench for sd_fifo_ctrl: behavioural BRAM, queue-based reference model,
// directed vector table, corner-case sequences and randomized traffic.
module tb_sd_fifo_ctrl;

  localparam int unsigned DATA  = 32;
  localparam int unsigned ADDR  = 7;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned CW    = ADDR + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            wr_valid;
  logic            wr_ready;
  logic [DATA-1:0] wr_data;
  logic            rd_valid;
  logic            rd_ready;
  logic [DATA-1:0] rd_data;
  logic [CW-1:0]   level;
  logic [CW-1:0]   thresh;
  logic            at_thresh;
  logic            mem_wr;
  logic [ADDR-1:0] mem_waddr;
  logic [DATA-1:0] mem_wdata;
  logic [ADDR-1:0] mem_raddr;
  logic [DATA-1:0] mem_rdout;

  always #5 clk = ~clk;

  sd_fifo_ctrl #(.DATA(DATA), .ADDR(ADDR)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .flush_i     (flush),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .wr_data_i   (wr_data),
    .rd_valid_o  (rd_valid),
    .rd_ready_i  (rd_ready),
    .rd_data_o   (rd_data),
    .level_o     (level),
    .thresh_i    (thresh),
    .at_thresh_o (at_thresh),
    .mem_wr_o    (mem_wr),
    .mem_waddr_o (mem_waddr),
    .mem_wdata_o (mem_wdata),
    .mem_raddr_o (mem_raddr),
    .mem_rdout_i (mem_rdout)
  );

  // Dual-port BRAM: registered read, read-old-data on a same-edge collision.
  logic [DATA-1:0] bram [DEPTH];
  always_ff @(posedge clk) begin
    if (mem_wr) bram[mem_waddr] <= mem_wdata;
    mem_rdout <= bram[mem_raddr];
  end

  // Reference model: a queue of words tagged with the cycle they were pushed.
  typedef struct {
    logic [DATA-1:0] data;
    int unsigned     cyc;
  } ent_t;
  ent_t        mq[$];
  int unsigned cyc;
  logic        at_exp;

  int tests;
  int fails;

  // Samples captured at the check point of the last step.
  logic            s_valid, s_wr_ready, s_at, s_wr, s_pop;
  logic [DATA-1:0] s_data;
  logic [CW-1:0]   s_level;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic model_valid();
    return (mq.size() != 0) && (cyc >= mq[0].cyc + 2);
  endfunction

  task automatic step(input logic wv, input logic [DATA-1:0] wd, input logic rr, input logic fl);
    logic exp_rdy, exp_val, push, pop;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    flush    = fl;
    #3;
    exp_rdy = rst_n && !fl && (mq.size() != DEPTH);
    exp_val = model_valid();
    push    = wv && exp_rdy;
    pop     = exp_val && rr && !fl;
    chk("wr_ready", 64'(wr_ready), 64'(exp_rdy));
    chk("rd_valid", 64'(rd_valid), 64'(exp_val));
    chk("level", 64'(level), 64'(mq.size()));
    chk("at_thresh", 64'(at_thresh), 64'(at_exp));
    chk("mem_wr", 64'(mem_wr), 64'(push));
    if (exp_val) chk("rd_data", 64'(rd_data), 64'(mq[0].data));
    s_valid = rd_valid; s_data = rd_data; s_level = level;
    s_wr_ready = wr_ready; s_at = at_thresh; s_wr = mem_wr; s_pop = pop;
    @(posedge clk);
    if (!rst_n || fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{data: wd, cyc: cyc});
    end
    at_exp = (32'(mq.size()) >= 32'(thresh));
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic            wv;
    logic [DATA-1:0] wd;
    logic            rr;
    logic            fl;
    logic            ev;
    logic [DATA-1:0] ed;
    logic [CW-1:0]   el;
    logic            ewr;
  } vec_t;

  initial begin
    vec_t tbl[7];
    int   max_lvl, gaps, npop;

    tests = 0; fails = 0; cyc = 0;
    rst_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    wr_data = '0; thresh = CW'(128);
    mq.delete();
    @(posedge clk); #1;
    at_exp = 1'b0;

    // Reset values while rst_n is held low, then release.
    step(1'b1, 32'h1111, 1'b1, 1'b0);
    chk("reset_raddr", 64'(mem_raddr), 64'd0);
    rst_n = 1'b1;

    // Directed vectors: single write, read-back latency, flush masking.
    tbl[0] = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, '0, CW'(0), 1'b1};
    tbl[1] = '{1'b0, '0, 1'b0, 1'b0, 1'b0, '0, CW'(1), 1'b0};
    tbl[2] = '{1'b0, '0, 1'b0, 1'b0, 1'b1, 32'hA5A5_0001, CW'(1), 1'b0};
    tbl[3] = '{1'b0, '0, 1'b1, 1'b0, 1'b1, 32'hA5A5_0001, CW'(1), 1'b0};
    tbl[4] = '{1'b0, '0, 1'b0, 1'b0, 1'b0, '0, CW'(0), 1'b0};
    tbl[5] = '{1'b1, 32'h5555, 1'b1, 1'b1, 1'b0, '0, CW'(0), 1'b0};
    tbl[6] = '{1'b0, '0, 1'b0, 1'b0, 1'b0, '0, CW'(0), 1'b0};
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].wv, tbl[i].wd, tbl[i].rr, tbl[i].fl);
      chk($sformatf("vec%0d_valid", i), 64'(s_valid), 64'(tbl[i].ev));
      chk($sformatf("vec%0d_level", i), 64'(s_level), 64'(tbl[i].el));
      chk($sformatf("vec%0d_mem_wr", i), 64'(s_wr), 64'(tbl[i].ewr));
      if (tbl[i].ev) chk($sformatf("vec%0d_data", i), 64'(s_data), 64'(tbl[i].ed));
    end

    // Fill to full with thresh 128, offer a 129th word, then drain.
    thresh = CW'(128);
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 128; i++) step(1'b1, DATA'(i), 1'b0, 1'b0);
    step(1'b1, 32'h999, 1'b0, 1'b0);
    chk("full_wr_ready", 64'(s_wr_ready), 64'd0);
    chk("full_level", 64'(s_level), 64'd128);
    chk("full_at_thresh", 64'(s_at), 64'd1);
    chk("full_mem_wr", 64'(s_wr), 64'd0);
    for (int i = 0; i < 131; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("drained_level", 64'(level), 64'd0);

    // Streaming push+pop every cycle.
    thresh = CW'(2);
    step(1'b0, '0, 1'b0, 1'b1);
    max_lvl = 0; gaps = 0; npop = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, DATA'(1000 + i), 1'b1, 1'b0);
      if (int'(s_level) > max_lvl) max_lvl = int'(s_level);
      if (i >= 2 && !s_valid) gaps++;
      if (s_pop) npop++;
    end
    chk("stream_max_level", 64'(max_lvl), 64'd2);
    chk("stream_gaps", 64'(gaps), 64'd0);
    chk("stream_pops", 64'(npop), 64'd298);
    idle(4);

    // Pointer wrap: 100 in, 100 out, then 100..199 across the 127->0 boundary.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) step(1'b1, DATA'(i), 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 100; i++) step(1'b0, '0, 1'b1, 1'b0);
    npop = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, DATA'(100 + i), 1'b1, 1'b0);
      if (s_pop) npop++;
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      if (s_pop) npop++;
    end
    chk("wrap_pops", 64'(npop), 64'd100);

    // Simultaneous push and pop at level 5.
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, DATA'(50 + i), 1'b0, 1'b0);
    idle(2);
    step(1'b1, DATA'(55), 1'b1, 1'b0);
    chk("pp_head_before", 64'(s_data), 64'd50);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("pp_level", 64'(s_level), 64'd5);
    chk("pp_head_after", 64'(s_data), 64'd51);

    // Flush with push and pop asserted at level 40.
    for (int i = 0; i < 35; i++) step(1'b1, DATA'(200 + i), 1'b0, 1'b0);
    idle(2);
    step(1'b1, 32'hDEAD, 1'b1, 1'b1);
    chk("flush_mem_wr", 64'(s_wr), 64'd0);
    chk("flush_level_before", 64'(s_level), 64'd40);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("flush_level", 64'(s_level), 64'd0);
    chk("flush_valid", 64'(s_valid), 64'd0);
    step(1'b1, 32'h1234, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("post_flush_valid_early", 64'(s_valid), 64'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("post_flush_valid", 64'(s_valid), 64'd1);
    chk("post_flush_data", 64'(s_data), 64'h1234);

    // Reset mid-stream discards contents.
    for (int i = 0; i < 10; i++) step(1'b1, DATA'(300 + i), 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 32'h77, 1'b1, 1'b0);
    chk("rst_wr_ready", 64'(s_wr_ready), 64'd0);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    chk("rst_level", 64'(s_level), 64'd0);

    // Randomized traffic with varying bias and occasional flush/threshold change.
    for (int blk = 0; blk < 12; blk++) begin
      int unsigned pw, pr;
      thresh = CW'($urandom_range(0, 128));
      pw = $urandom_range(10, 95);
      pr = $urandom_range(10, 95);
      for (int i = 0; i < 250; i++) begin
        step(($urandom_range(0, 99) < pw), $urandom, ($urandom_range(0, 99) < pr),
             ($urandom_range(0, 199) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
